inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Issues a request to instruction memory for the current PC, with one outstanding request at a time.
- Registers the returned instruction for decode, with an address tag and a valid bit.
- Requests a PC hold until the fetch completes; jumps flush and redirect it.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, instruction width
HOLD_W, 3, width of the hold bus
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
pc  in  ADDR_W  current PC from the PC register
hold  in  HOLD_W  downstream hold bus; hold_flag = |hold
jump  in  1  redirect/flush from execute
ibus_req  out  1  memory request valid
ibus_addr  out  ADDR_W  request address (= pc)
ibus_gnt  in  1  request accepted this cycle
ibus_rvalid  in  1  response data valid (single cycle)
ibus_rdata  in  DATA_W  response instruction
stall_req  out  1  hold request to the PC register
inst_valid  out  1  decode slot holds a real instruction
inst  out  DATA_W  instruction to decode
inst_addr  out  ADDR_W  address of inst

Behaviour:
- Clock/reset: one clock, clk. Reset is rstn, asynchronous and active-low.
- Reset values:
  - state = REQ, drop = 0.
  - inst = NOP_INST, inst_addr = 0, inst_valid = 0.
  - Buffer cleared.
  - Instruction memory must be reset by the same rstn; a response to a request aborted by reset must never arrive.
- State REQ:
  - ibus_req = 1, ibus_addr = pc (combinational).
  - On ibus_gnt: latch req_addr <= pc, go to RSP.
  - pc is stable while stall_req = 1.
- State RSP: wait for ibus_rvalid; ibus_req = 0.
  - If drop = 1: discard the data, drop <= 0, go to REQ.
  - Else if hold_flag = 0: inst <= ibus_rdata, inst_addr <= req_addr, inst_valid <= 1, go to REQ.
  - Else (held): capture ibus_rdata/req_addr into a one-entry buffer, go to BUF.
- State BUF: wait for hold_flag = 0.
  - Then load the buffer into the output register (valid = 1) and go to REQ.
- stall_req:
  - 0 in the cycle of an accepted response (RSP & rvalid & !drop & !hold_flag).
  - 0 in the BUF release cycle.
  - 0 whenever jump = 1 (so hold and jump are never asserted together).
  - 1 otherwise.
  - Net effect: the PC advances exactly once per delivered instruction.
- Output register when no instruction is delivered this cycle:
  - hold_flag = 1: all outputs held.
  - hold_flag = 0: inst <= NOP_INST, inst_valid <= 0 (bubble); inst_addr holds.
- Jump (has priority over everything):
  - Output is flushed: inst <= NOP_INST, inst_valid <= 0.
  - REQ without gnt: stay in REQ. The next cycle requests the new pc.
  - REQ with gnt in the same cycle: go to RSP with drop = 1.
  - RSP without rvalid: drop <= 1.
  - RSP with rvalid in the same cycle: discard the data, go to REQ.
  - BUF: discard the buffer, go to REQ.
- Throughput and latency:
  - Best case is one instruction per 2 cycles (gnt in the REQ cycle, rvalid the next cycle).
  - The result is visible on inst the cycle after rvalid.
- ibus_addr and ibus_req must not change while ibus_req = 1 and ibus_gnt = 0, unless jump is asserted.

Test Plan:
- Reset, then pc = 0x0, gnt immediate, rvalid one cycle later with 0x00500093 -> inst = 0x00500093, inst_addr = 0, inst_valid = 1 two cycles after gnt; stall_req low for exactly the rvalid cycle.
- gnt delayed 3 cycles -> ibus_addr stays 0x4; stall_req stays 1; inst_valid = 0 with inst = NOP_INST meanwhile.
- rvalid arrives with hold = 3'b010 for 4 cycles -> outputs frozen; data buffered (BUF); released the cycle after hold clears; stall_req pulses low once; no instruction is lost or duplicated.
- jump while in RSP for pc = 0x8 -> the later rvalid data is discarded; the next request has the new pc = 0x100; inst_valid = 0 until the 0x100 data arrives; inst_addr = 0x100.
- jump in the same cycle as gnt -> the response is dropped; inst_valid never shows the stale address.
- rstn asserted mid-RSP -> all outputs return to reset values asynchronously; fetch restarts at the pc reset value after release.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding ibus request, registered decode slot,
// one-entry buffer for responses that arrive while decode is held.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                HOLD_W   = 3,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc,
  input  logic [HOLD_W-1:0] hold,
  input  logic              jump,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_gnt,
  input  logic              ibus_rvalid,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic              stall_req,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [1:0]        dbg_state
);

  // ibus handshake: a request transfers on a cycle with ibus_req & ibus_gnt; its
  // single-cycle response (ibus_rvalid) comes on a later cycle and cannot be refused.
  typedef enum logic [1:0] {
    S_REQ = 2'd0,
    S_RSP = 2'd1,
    S_BUF = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;
  logic              r_inst_valid;
  logic [DATA_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_inst_addr;

  logic w_hold_flag;
  logic w_latch_req;
  logic w_deliver_rsp;
  logic w_deliver_buf;
  logic w_capture_buf;

  assign w_hold_flag = |hold;

  always_comb begin
    w_state_nxt   = r_state;
    w_drop_nxt    = r_drop;
    w_latch_req   = 1'b0;
    w_deliver_rsp = 1'b0;
    w_deliver_buf = 1'b0;
    w_capture_buf = 1'b0;
    case (r_state)
      S_REQ: begin
        if (ibus_gnt) begin
          w_latch_req = 1'b1;
          w_state_nxt = S_RSP;
          w_drop_nxt  = jump;
        end
      end
      S_RSP: begin
        if (ibus_rvalid) begin
          w_state_nxt = S_REQ;
          w_drop_nxt  = 1'b0;
          if (!r_drop && !jump) begin
            if (!w_hold_flag) begin
              w_deliver_rsp = 1'b1;
            end else begin
              w_capture_buf = 1'b1;
              w_state_nxt   = S_BUF;
            end
          end
        end else if (jump) begin
          // Response still owed by memory; it must be swallowed when it lands.
          w_drop_nxt = 1'b1;
        end
      end
      S_BUF: begin
        if (jump) begin
          w_state_nxt = S_REQ;
        end else if (!w_hold_flag) begin
          w_deliver_buf = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign ibus_req   = (r_state == S_REQ);
  assign ibus_addr  = pc;
  assign stall_req  = !(jump || w_deliver_rsp || w_deliver_buf);
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_addr  = r_inst_addr;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_REQ;
      r_drop     <= 1'b0;
      r_req_addr <= '0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_latch_req) r_req_addr <= pc;
      if (w_capture_buf) begin
        r_buf_data <= ibus_rdata;
        r_buf_addr <= r_req_addr;
      end
    end
  end

  // Decode slot: jump flushes, delivery loads, otherwise bubble unless held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inst       <= NOP_INST;
      r_inst_addr  <= '0;
      r_inst_valid <= 1'b0;
    end else if (jump) begin
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
    end else if (w_deliver_rsp) begin
      r_inst       <= ibus_rdata;
      r_inst_addr  <= r_req_addr;
      r_inst_valid <= 1'b1;
    end else if (w_deliver_buf) begin
      r_inst       <= r_buf_data;
      r_inst_addr  <= r_buf_addr;
      r_inst_valid <= 1'b1;
    end else if (!w_hold_flag) begin
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
    end
  end

endmodule
